// File: rtl/mem_arbiter_if.sv
// Request/response and single-port memory signals shared by the two requesters and mem_arbiter.
// Port 0 is instruction fetch, port 1 is data.
interface mem_arbiter_if #(
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned ADDRWIDTH = 32
);
  logic [1:0]           req_i;
  logic [1:0]           we_i;
  logic [ADDRWIDTH-1:0] addr0_i;
  logic [ADDRWIDTH-1:0] addr1_i;
  logic [DATAWIDTH-1:0] wdata0_i;
  logic [DATAWIDTH-1:0] wdata1_i;
  logic [1:0]           gnt_o;
  logic [1:0]           rvalid_o;
  logic [DATAWIDTH-1:0] rdata_o;
  logic                 mem_re_o;
  logic                 mem_we_o;
  logic [ADDRWIDTH-1:0] mem_addr_o;
  logic [DATAWIDTH-1:0] mem_wdata_o;
  logic [DATAWIDTH-1:0] mem_rdata_i;

  // Requesters and memory model side
  modport master (
    output req_i, we_i, addr0_i, addr1_i, wdata0_i, wdata1_i, mem_rdata_i,
    input  gnt_o, rvalid_o, rdata_o, mem_re_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  // Arbiter side
  modport slave (
    input  req_i, we_i, addr0_i, addr1_i, wdata0_i, wdata1_i, mem_rdata_i,
    output gnt_o, rvalid_o, rdata_o, mem_re_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port memory with one-cycle read latency.
// Grants are same-cycle combinational; read data returns on the shared bus one cycle later.
module mem_arbiter #(
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned ADDRWIDTH = 32
) (
  input logic          clk_i,
  input logic          rst_i,
  mem_arbiter_if.slave bus
);
  localparam int unsigned CNTW = 16;

  logic            last_port_q;
  logic            rsp_pending_q;
  logic            rsp_port_q;
  logic [CNTW-1:0] grant_cnt_q;

  logic [1:0] gnt_c;
  logic       sel_port_c;
  logic       sel_we_c;

  // Arbitration: on contention the port not granted last wins; nothing is granted in reset.
  always_comb begin
    gnt_c      = 2'b00;
    sel_port_c = 1'b0;
    if (rst_i) begin
      case (bus.req_i)
        2'b01: begin
          gnt_c      = 2'b01;
          sel_port_c = 1'b0;
        end
        2'b10: begin
          gnt_c      = 2'b10;
          sel_port_c = 1'b1;
        end
        2'b11: begin
          sel_port_c = ~last_port_q;
          gnt_c      = sel_port_c ? 2'b10 : 2'b01;
        end
        default: begin
          gnt_c      = 2'b00;
          sel_port_c = 1'b0;
        end
      endcase
    end
  end

  assign sel_we_c = sel_port_c ? bus.we_i[1] : bus.we_i[0];

  // Memory-side mux and response return
  always_comb begin
    bus.gnt_o       = gnt_c;
    bus.mem_re_o    = 1'b0;
    bus.mem_we_o    = 1'b0;
    bus.mem_addr_o  = ADDRWIDTH'(0);
    bus.mem_wdata_o = DATAWIDTH'(0);
    bus.rvalid_o    = 2'b00;
    bus.rdata_o     = DATAWIDTH'(0);
    if (|gnt_c) begin
      bus.mem_re_o    = ~sel_we_c;
      bus.mem_we_o    = sel_we_c;
      bus.mem_addr_o  = sel_port_c ? bus.addr1_i : bus.addr0_i;
      bus.mem_wdata_o = sel_port_c ? bus.wdata1_i : bus.wdata0_i;
    end
    if (rsp_pending_q) begin
      bus.rvalid_o = rsp_port_q ? 2'b10 : 2'b01;
      bus.rdata_o  = bus.mem_rdata_i;
    end
  end

  // Pointer reset to 0 so port 1 wins the first contention; a reset drops any outstanding read.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      last_port_q   <= 1'b0;
      rsp_pending_q <= 1'b0;
      rsp_port_q    <= 1'b0;
      grant_cnt_q   <= CNTW'(0);
    end else if (|gnt_c) begin
      last_port_q   <= sel_port_c;
      rsp_pending_q <= ~sel_we_c;
      rsp_port_q    <= sel_port_c;
      grant_cnt_q   <= grant_cnt_q + CNTW'(1);
    end else begin
      rsp_pending_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and random traffic for mem_arbiter, scored against a transaction-level model
// (grant ages, shadow memory, expected-response queue).
module tb_mem_arbiter;
  logic clk;
  logic rst_n;

  mem_arbiter_if #(.DATAWIDTH(32), .ADDRWIDTH(32)) bus ();

  mem_arbiter #(.DATAWIDTH(32), .ADDRWIDTH(32)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return ({24'd0, a[7:0]} * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Single-port memory environment: one-cycle read latency, contents lost on reset.
  logic [31:0] mem_store [64];
  logic [63:0] mem_written;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_written     <= '0;
      bus.mem_rdata_i <= '0;
    end else begin
      if (bus.mem_we_o) begin
        mem_store[bus.mem_addr_o[7:2]]   <= bus.mem_wdata_o;
        mem_written[bus.mem_addr_o[7:2]] <= 1'b1;
      end
      if (bus.mem_re_o)
        bus.mem_rdata_i <= mem_written[bus.mem_addr_o[7:2]] ? mem_store[bus.mem_addr_o[7:2]]
                                                           : init_word(bus.mem_addr_o);
      else
        bus.mem_rdata_i <= 32'hBAD0_BAD0;
    end
  end

  typedef struct {
    int          due;
    bit          port;
    logic [31:0] data;
  } rsp_t;

  rsp_t        rsp_q[$];
  logic [31:0] ref_mem[logic [31:0]];
  int          last_cyc[2];
  int          waits[2];
  int          cyc;
  int          n_checks;
  int          n_pass;
  int          n_fail;

  bit          p_act[2];
  logic        p_we[2];
  logic [31:0] p_addr[2];
  logic [31:0] p_wdata[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  // A new request only replaces an idle port; a held request keeps its fields.
  task automatic arm(input bit p, input logic we, input logic [31:0] a, input logic [31:0] d);
    if (!p_act[p]) begin
      p_act[p]   = 1'b1;
      p_we[p]    = we;
      p_addr[p]  = a;
      p_wdata[p] = d;
    end
  endtask

  // Drive requests at the falling edge, sample 1ns later, and score against the model.
  task automatic cycle();
    logic [1:0]  eg;
    logic [1:0]  erv;
    logic [31:0] erd;
    bit          has_win;
    bit          win;
    bus.req_i    = {p_act[1], p_act[0]};
    bus.we_i     = {p_we[1], p_we[0]};
    bus.addr0_i  = p_addr[0];
    bus.addr1_i  = p_addr[1];
    bus.wdata0_i = p_wdata[0];
    bus.wdata1_i = p_wdata[1];
    #1;
    eg      = 2'b00;
    erv     = 2'b00;
    erd     = 32'd0;
    has_win = 1'b0;
    win     = 1'b0;
    if (!rst_n) begin
      rsp_q.delete();
      ref_mem.delete();
      last_cyc[0] = -1;
      last_cyc[1] = -2;
      waits[0]    = 0;
      waits[1]    = 0;
    end else begin
      if (p_act[0] && p_act[1]) begin
        has_win = 1'b1;
        win     = (last_cyc[1] < last_cyc[0]);
      end else if (p_act[0] || p_act[1]) begin
        has_win = 1'b1;
        win     = p_act[1];
      end
      if (has_win) eg = win ? 2'b10 : 2'b01;
      if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
        erv = rsp_q[0].port ? 2'b10 : 2'b01;
        erd = rsp_q[0].data;
        void'(rsp_q.pop_front());
      end
    end
    chk("gnt", 32'(bus.gnt_o), 32'(eg));
    chk("rvalid", 32'(bus.rvalid_o), 32'(erv));
    if (erv != 2'b00 || !rst_n) chk("rdata", bus.rdata_o, erd);
    chk("mem_re", 32'(bus.mem_re_o), 32'(has_win && !p_we[win]));
    chk("mem_we", 32'(bus.mem_we_o), 32'(has_win && p_we[win]));
    if (has_win) begin
      chk("mem_addr", bus.mem_addr_o, p_addr[win]);
      chk("mem_wdata", bus.mem_wdata_o, p_wdata[win]);
      if (p_we[win]) ref_mem[p_addr[win]] = p_wdata[win];
      else rsp_q.push_back('{due: cyc + 1, port: win, data: ref_rd(p_addr[win])});
      last_cyc[win] = cyc;
      p_act[win]    = 1'b0;
      waits[win]    = 0;
    end
    for (int p = 0; p < 2; p++) begin
      if (rst_n && p_act[p]) begin
        waits[p]++;
        chk($sformatf("starve_p%0d", p), 32'(waits[p] > 1), 32'd0);
      end
    end
    cyc++;
  endtask

  task automatic advance();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cycle();
      advance();
    end
  endtask

  initial begin
    logic [1:0] rr_seq [4];
    rr_seq   = '{2'b10, 2'b01, 2'b10, 2'b01};
    n_checks = 0;
    n_pass   = 0;
    n_fail   = 0;
    cyc      = 0;
    for (int p = 0; p < 2; p++) begin
      p_act[p]   = 1'b0;
      p_we[p]    = 1'b0;
      p_addr[p]  = 32'd0;
      p_wdata[p] = 32'd0;
    end
    rst_n = 1'b0;
    advance();

    // Requests present during reset must see no grant and no memory activity
    arm(1'b0, 1'b0, 32'h30, 32'd0);
    arm(1'b1, 1'b0, 32'h34, 32'd0);
    cycle();
    chk("reset_gnt", 32'(bus.gnt_o), 32'd0);
    chk("reset_mem_re", 32'(bus.mem_re_o), 32'd0);
    advance();
    rst_n = 1'b1;

    // Both held from reset: data port wins first, then strict alternation
    for (int i = 0; i < 4; i++) begin
      arm(1'b0, 1'b0, 32'h30 + 32'(i * 8), 32'd0);
      arm(1'b1, 1'b0, 32'h34 + 32'(i * 8), 32'd0);
      cycle();
      chk($sformatf("rr_seq%0d", i), 32'(bus.gnt_o), 32'(rr_seq[i]));
      advance();
    end
    for (int i = 0; i < 4 && (p_act[0] || p_act[1]); i++) idle(1);
    idle(1);

    // Preload 0x10, then a lone instruction-port read of it
    arm(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
    idle(2);
    arm(1'b0, 1'b0, 32'h10, 32'd0);
    cycle();
    chk("single_gnt", 32'(bus.gnt_o), 32'h1);
    chk("single_re", 32'(bus.mem_re_o), 32'h1);
    chk("single_addr", bus.mem_addr_o, 32'h10);
    advance();
    cycle();
    chk("single_rvalid", 32'(bus.rvalid_o), 32'h1);
    chk("single_rdata", bus.rdata_o, 32'hDEAD_BEEF);
    advance();

    // Write by data port followed next cycle by a read of the same word
    arm(1'b1, 1'b1, 32'h20, 32'h55);
    cycle();
    chk("raw_we", 32'(bus.mem_we_o), 32'h1);
    advance();
    arm(1'b0, 1'b0, 32'h20, 32'd0);
    cycle();
    advance();
    cycle();
    chk("raw_rvalid", 32'(bus.rvalid_o), 32'h1);
    chk("raw_rdata", bus.rdata_o, 32'h55);
    advance();

    // Back-to-back reads overlap each grant with the previous response
    for (int i = 0; i < 3; i++) begin
      arm(1'b0, 1'b0, 32'(i * 4), 32'd0);
      cycle();
      chk($sformatf("b2b_gnt%0d", i), 32'(bus.gnt_o), 32'h1);
      if (i > 0) chk($sformatf("b2b_rvalid%0d", i), 32'(bus.rvalid_o), 32'h1);
      advance();
    end
    cycle();
    chk("b2b_rvalid_last", 32'(bus.rvalid_o), 32'h1);
    advance();

    // Reset while a read response is due: the response is dropped for good
    arm(1'b0, 1'b0, 32'h4, 32'd0);
    cycle();
    advance();
    rst_n = 1'b0;
    cycle();
    chk("rst_drop_rvalid", 32'(bus.rvalid_o), 32'd0);
    chk("rst_drop_rdata", bus.rdata_o, 32'd0);
    advance();
    rst_n = 1'b1;
    cycle();
    chk("post_rst_rvalid", 32'(bus.rvalid_o), 32'd0);
    advance();

    // Random mixed traffic on a small address window to force read-after-write hits
    for (int n = 0; n < 10000; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!p_act[p] && $urandom_range(0, 9) < 6)
          arm(p[0], ($urandom_range(0, 2) == 0), 32'($urandom_range(0, 15)) << 2, $urandom);
      end
      cycle();
      advance();
    end
    p_act[0] = 1'b0;
    p_act[1] = 1'b0;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATAWIDTH, default 32, SHALL set the data width of all data buses.
REQ-002 Parameter ADDRWIDTH, default 32, SHALL set the width of all address buses.
REQ-003 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  SHALL be the reset, asynchronous and active-low.
REQ-005 req_i[1:0]  input  2  SHALL be per-port request; port 0 = instruction fetch, port 1 = data.
REQ-006 we_i[1:0]  input  2  SHALL be per-port write-not-read qualifier.
REQ-007 addr0_i, addr1_i  input  ADDRWIDTH  SHALL be per-port byte addresses.
REQ-008 wdata0_i, wdata1_i  input  DATAWIDTH  SHALL be per-port write data.
REQ-009 gnt_o[1:0]  output  2  SHALL be per-port grant (request accepted this cycle).
REQ-010 rvalid_o[1:0]  output  2  SHALL be per-port read-data valid.
REQ-011 rdata_o  output  DATAWIDTH  SHALL be shared read-data return bus.
REQ-012 mem_re_o, mem_we_o  output  1 each  SHALL be single-port memory read/write enables.
REQ-013 mem_addr_o  output  ADDRWIDTH  SHALL be memory address.
REQ-014 mem_wdata_o  output  DATAWIDTH  SHALL be memory write data.
REQ-015 mem_rdata_i  input  DATAWIDTH  SHALL be memory read data, valid one cycle after mem_re_o.

Function
REQ-016 Requester rule: req/we/addr/wdata SHALL be held stable from assertion until the cycle gnt is seen; the arbiter need not handle deassertion without grant.
REQ-017 At most one gnt_o bit SHALL be high per cycle; gnt_o SHALL be combinational from req_i and state (same-cycle grant).
REQ-018 Single request: grant that port immediately.
REQ-019 Both requesting: grant the port not granted most recently (round-robin); last-grant pointer updates only on a grant.
REQ-020 After reset, the pointer SHALL favour port 1 (data) on the first contention.
REQ-021 On grant: mem_addr_o/mem_wdata_o SHALL mux the granted port; mem_we_o = granted we; mem_re_o = granted not we; all memory enables 0 when no grant.
REQ-022 Read grant SHALL register rsp_pending=1 and rsp_port=granted port; next cycle rvalid_o[rsp_port]=1, rdata_o=mem_rdata_i; latency exactly 1 cycle.
REQ-023 Write grant SHALL produce no rvalid; write completes in the grant cycle.
REQ-024 Grants SHALL be pipelined: a new grant may issue in the same cycle as a prior read's rvalid; sustained throughput 1 access/cycle.
REQ-025 rdata_o SHALL equal mem_rdata_i when an rvalid bit is high; value otherwise unspecified (0 preferred).
REQ-026 rvalid_o SHALL be one-hot or zero; never both bits.
REQ-027 Per-port starvation bound: a held request SHALL be granted within 2 cycles of assertion.
REQ-028 Optional state counter grant_cnt (16 bit, wraps 0xFFFF->0) SHALL count grants; internal only, debug visible.

Reset
REQ-029 rst_i low SHALL immediately (asynchronously) clear rsp_pending, rsp_port=0, pointer to favour port 1, grant_cnt=0.
REQ-030 During reset: gnt_o=0, rvalid_o=0, mem_re_o=0, mem_we_o=0, rdata_o=0, regardless of req_i.
REQ-031 Reset asserted with a read outstanding SHALL drop its response; no rvalid after reset release.
REQ-032 First grant SHALL be possible in the first rising edge cycle after rst_i rises.

Verification
REQ-033 Only port 0 reads 0x10, memory holds 0xDEADBEEF -> gnt_o=01 cycle N, mem_re_o=1, mem_addr_o=0x10; rvalid_o=01, rdata_o=0xDEADBEEF cycle N+1.
REQ-034 Both ports request from reset, held 4 cycles -> gnt_o sequence 10,01,10,01 (after re-request) ; never 11.
REQ-035 Port 1 writes 0x55 to 0x20 while port 0 reads 0x20 next cycle -> mem_we_o=1 cycle N, read returns 0x55 cycle N+2, rvalid_o[1] never set.
REQ-036 Back-to-back reads port 0 addr 0x0,0x4,0x8 -> gnt every cycle, rvalid_o[0] high three consecutive cycles with matching data.
REQ-037 Read granted cycle N, rst_i low during cycle N+1 -> rvalid_o=00 immediately and after release; all outputs 0 during reset.
REQ-038 Random traffic 10k cycles -> scoreboard: every read returns correct data on correct port, no request waits more than 2 cycles.
